// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-rate presets at 100 MHz and frame constants.
package uart_pkg;

    localparam int unsigned ClksPerBit9600   = 10417;
    localparam int unsigned ClksPerBit115200 = 868;
    localparam int unsigned DataBitsPerFrame = 8;
    localparam logic        IdleLevel        = 1'b1;

    // Fixed encodings so transmitter and receiver agree on state values.
    typedef enum logic [2:0] {
        Idle      = 3'd0,
        StartBit  = 3'd1,
        DataBits  = 3'd2,
        ParityBit = 3'd3,
        StopBit   = 3'd4,
        CleanUp   = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit timer: counts 0..ClocksPerBit-1 and pulses BitEnd on the last count.
module uart_bit_timer #(
    parameter int unsigned ClocksPerBit = 16,
    parameter int unsigned CounterWidth = $clog2(ClocksPerBit)
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Clear,
    output logic BitEnd
);

    localparam logic [CounterWidth-1:0] LastCount = CounterWidth'(ClocksPerBit - 1);

    logic [CounterWidth-1:0] r_count;
    logic                    w_at_last;

    assign w_at_last = (r_count == LastCount);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else if (Clear || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign BitEnd = w_at_last && !Clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter; define UART_TX_PARITY_EN to insert a parity bit (sense set by ParityOdd).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned ClocksPerBit = ClksPerBit9600,
    parameter int unsigned CounterWidth = $clog2(ClocksPerBit),
    parameter int unsigned ParityOdd    = 0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       TxStart,
    input  logic [7:0] TxDataIn,
    output logic       TxSerial,
    output logic       TxBusy,
    output logic       TxDone
);

    localparam logic [2:0] LastBitIdx = 3'(DataBitsPerFrame - 1);

    if (ClocksPerBit < 4 || ClocksPerBit > 65535) begin : g_bad_clocks_per_bit
        $error("uart_tx_serializer: ClocksPerBit must be in 4..65535");
    end
    if (ParityOdd > 1) begin : g_bad_parity_odd
        $error("uart_tx_serializer: ParityOdd must be 0 or 1");
    end

    uart_state_e r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_tx_serial;
    logic        r_busy;
    logic        r_done;

    uart_state_e w_state_next;
    logic [7:0]  w_shift_next;
    logic [2:0]  w_idx_next;
    logic        w_serial_next;
    logic        w_timer_clear;
    logic        w_bit_end;

    uart_bit_timer #(
        .ClocksPerBit (ClocksPerBit),
        .CounterWidth (CounterWidth)
    ) u_bit_timer (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Clear  (w_timer_clear),
        .BitEnd (w_bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic w_parity;
    assign w_parity = (^w_shift_next) ^ (ParityOdd != 0);
`endif

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_idx_next    = r_bit_idx;
        w_timer_clear = 1'b0;
        case (r_state)
            Idle, CleanUp: begin
                w_timer_clear = 1'b1;
                w_state_next  = Idle;
                if (TxStart) begin
                    w_state_next = StartBit;
                    w_shift_next = TxDataIn;
                end
            end
            StartBit: begin
                if (w_bit_end) w_state_next = DataBits;
            end
            DataBits: begin
                if (w_bit_end) begin
                    if (r_bit_idx == LastBitIdx) begin
                        w_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = ParityBit;
`else
                        w_state_next = StopBit;
`endif
                    end else begin
                        w_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ParityBit: begin
                if (w_bit_end) w_state_next = StopBit;
            end
`endif
            StopBit: begin
                if (w_bit_end) w_state_next = CleanUp;
            end
            default: begin
                w_timer_clear = 1'b1;
                w_state_next  = Idle;
                w_idx_next    = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave a register glitch-free.
        w_serial_next = IdleLevel;
        case (w_state_next)
            StartBit:  w_serial_next = ~IdleLevel;
            DataBits:  w_serial_next = w_shift_next[w_idx_next];
`ifdef UART_TX_PARITY_EN
            ParityBit: w_serial_next = w_parity;
`endif
            default:   w_serial_next = IdleLevel;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= Idle;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_tx_serial <= IdleLevel;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_idx   <= w_idx_next;
            r_tx_serial <= w_serial_next;
            r_busy      <= (w_state_next != Idle) && (w_state_next != CleanUp);
            r_done      <= (w_state_next == CleanUp);
        end
    end

    assign TxSerial = r_tx_serial;
    assign TxBusy   = r_busy;
    assign TxDone   = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table of bytes with expected line sequences, scoreboard queue.
module tb_uart_tx_serializer;

    localparam int unsigned CPB        = 16;
    localparam int unsigned PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       TxStart;
    logic [7:0] TxDataIn;
    logic       TxSerial;
    logic       TxBusy;
    logic       TxDone;

    int n_checks = 0;
    int n_errors = 0;

    // line: time-ordered start,d0..d7,stop with the first bit in the MSB; par: even parity of data
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
        logic       par;
    } exp_t;

    exp_t vec[8];
    exp_t sb_q[$];

    uart_tx_serializer #(
        .ClocksPerBit (CPB),
        .ParityOdd    (PARITY_ODD)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .TxStart  (TxStart),
        .TxDataIn (TxDataIn),
        .TxSerial (TxSerial),
        .TxBusy   (TxBusy),
        .TxDone   (TxDone)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input exp_t e, input int b);
        if (b < 9) return e.line[9 - b];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return e.par ^ PARITY_ODD[0];
`endif
        return 1'b1;
    endfunction

    // Called at a negedge; leaves the bench at the negedge holding the first start-bit sample.
    task automatic send(input int idx);
        TxStart  = 1'b1;
        TxDataIn = vec[idx].data;
        sb_q.push_back(vec[idx]);
        @(negedge Clk);
        TxStart = 1'b0;
        chk($sformatf("busy_on_accept_%02h", vec[idx].data), {31'd0, TxBusy}, 32'd1);
    endtask

    task automatic idle_check(input string name, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (TxSerial !== 1'b1 || TxBusy !== 1'b0 || TxDone !== 1'b0) bad++;
            @(negedge Clk);
        end
        chk(name, bad, 0);
    endtask

    task automatic run_frame(input int poke_cyc, input logic [7:0] poke_data,
                             input bit b2b, input int b2b_idx);
        exp_t e;
        int   bad_line;
        int   bad_ctl = 0;
        int   k;
        logic exp_bit;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got empty scoreboard, required a queued byte");
            return;
        end
        e = sb_q.pop_front();
        for (int b = 0; b < NBITS; b++) begin
            exp_bit  = frame_bit(e, b);
            bad_line = 0;
            for (int c = 0; c < int'(CPB); c++) begin
                if (TxSerial !== exp_bit) bad_line++;
                if (TxDone !== 1'b0 || TxBusy !== 1'b1) bad_ctl++;
                k = b * int'(CPB) + c;
                if (k == poke_cyc) begin
                    TxStart  = 1'b1;
                    TxDataIn = poke_data;
                end else if (k == poke_cyc + 1) begin
                    TxStart = 1'b0;
                end
                @(negedge Clk);
            end
            chk($sformatf("bit%0d_of_%02h_bad_cycles", b, e.data), bad_line, 0);
        end
        chk($sformatf("ctl_in_frame_%02h_bad_cycles", e.data), bad_ctl, 0);
        chk($sformatf("done_pulse_%02h", e.data), {31'd0, TxDone}, 32'd1);
        chk($sformatf("busy_cleanup_%02h", e.data), {31'd0, TxBusy}, 32'd0);
        chk($sformatf("line_cleanup_%02h", e.data), {31'd0, TxSerial}, 32'd1);
        if (b2b) begin
            TxStart  = 1'b1;
            TxDataIn = vec[b2b_idx].data;
            sb_q.push_back(vec[b2b_idx]);
            @(negedge Clk);
            TxStart = 1'b0;
            chk("b2b_done_single", {31'd0, TxDone}, 32'd0);
            chk("b2b_start_fall", {31'd0, TxSerial}, 32'd0);
            chk("b2b_busy", {31'd0, TxBusy}, 32'd1);
        end else begin
            @(negedge Clk);
            chk($sformatf("done_single_%02h", e.data), {31'd0, TxDone}, 32'd0);
            chk($sformatf("idle_after_%02h", e.data), {30'd0, TxBusy, TxSerial}, 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        int   bad;
        vec[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vec[1] = '{8'h00, 10'b0000000001, 1'b0};
        vec[2] = '{8'hFF, 10'b0111111111, 1'b0};
        vec[3] = '{8'h5A, 10'b0010110101, 1'b0};
        vec[4] = '{8'h81, 10'b0100000011, 1'b0};
        vec[5] = '{8'h07, 10'b0111000001, 1'b1};
        vec[6] = '{8'h55, 10'b0101010101, 1'b0};
        vec[7] = '{8'h3C, 10'b0001111001, 1'b0};

        Rst_n    = 1'b0;
        TxStart  = 1'b0;
        TxDataIn = 8'h00;
        @(negedge Clk);
        @(negedge Clk);
        chk("reset_line", {31'd0, TxSerial}, 32'd1);
        chk("reset_busy", {31'd0, TxBusy}, 32'd0);
        chk("reset_done", {31'd0, TxDone}, 32'd0);
        Rst_n = 1'b1;
        idle_check("idle_after_reset", 5);

        for (int i = 0; i < 8; i++) begin
            send(i);
            run_frame(-10, 8'h00, 1'b0, 0);
            idle_check($sformatf("gap_after_vec%0d", i), 3);
        end

        // Request while busy: ignored, in-flight frame and following idle unaffected.
        send(6);
        run_frame(40, 8'h3C, 1'b0, 0);
        idle_check("no_second_frame", 3 * int'(CPB));

        // Back-to-back: 0x00 requested in the CleanUp cycle of an 0xFF frame.
        send(2);
        run_frame(-10, 8'h00, 1'b1, 1);
        run_frame(-10, 8'h00, 1'b0, 0);
        idle_check("idle_after_b2b", 5);

        // Reset asserted during data bit 3 of an 0xA5 frame.
        send(0);
        e   = sb_q.pop_front();
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            if (TxSerial !== frame_bit(e, k / int'(CPB))) bad++;
            @(negedge Clk);
        end
        chk("rst_prefix_bad_cycles", bad, 0);
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_line", {31'd0, TxSerial}, 32'd1);
        chk("rst_mid_busy", {31'd0, TxBusy}, 32'd0);
        chk("rst_mid_done", {31'd0, TxDone}, 32'd0);
        @(negedge Clk);
        idle_check("held_in_reset", 20);
        Rst_n = 1'b1;
        idle_check("idle_after_rst_release", 2 * int'(CPB));
        send(3);
        run_frame(-10, 8'h00, 1'b0, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit-side companion to the team's UART receiver. Serialises one byte per request onto an 8N1 line at the same bit rate.
- Sits directly upstream of the receiver in loopback and board-to-board links; its TxSerial drives the receiver's Rx input.
- Same bit-timing parameter convention as the receiver, so both ends agree on baud without extra configuration.

Parameters:
- ClocksPerBit, 10417, input clock cycles per UART bit (100 MHz / 9600; 868 for 115200). Legal range 4..65535.
- CounterWidth, $clog2(ClocksPerBit), bit-timer width (derived; do not override).
- ParityOdd, 0, parity sense when the optional feature is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- Clk  input  1  system clock, 100 MHz
- Rst_n  input  1  asynchronous active-low reset
- TxStart  input  1  request: send TxDataIn; sampled only while TxBusy=0
- TxDataIn  input  8  byte to send, captured on the accepting edge
- TxSerial  output  1  UART line, idle high
- TxBusy  output  1  high from the accepting edge until the frame completes
- TxDone  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (async, Rst_n=0): TxSerial=1, TxBusy=0, TxDone=0, state=Idle, bit timer=0, bit index=0, shift register=0. Applies immediately, including mid-frame; the line returns high at once. After release the block waits in Idle.
- States: Idle, StartBit, DataBits, [ParityBit], StopBit, CleanUp. Any illegal encoding goes to Idle.
- Idle: TxSerial=1.
  - If TxStart=1, capture TxDataIn into the shift register, set TxBusy=1, and go to StartBit.
  - From the next edge, TxSerial=0.
- Bit timing: each bit is held exactly ClocksPerBit cycles. The timer counts 0..ClocksPerBit-1, then wraps to 0 and advances.
- StartBit: TxSerial=0 for ClocksPerBit cycles, then DataBits.
- DataBits: LSB first, TxSerial=shift[BitIndex], BitIndex 0..7.
  - After bit 7 ends, go to StopBit (or ParityBit if compiled in).
  - BitIndex resets to 0.
- StopBit: TxSerial=1 for ClocksPerBit cycles, then CleanUp.
- CleanUp: one cycle.
  - TxDone=1 and TxBusy=0 in this cycle; TxSerial=1.
  - Next state is Idle.
  - A TxStart seen in CleanUp is accepted exactly as in Idle (back-to-back support). The next start bit then begins on the following edge.
- Frame length: start-bit fall to TxDone is 10*ClocksPerBit cycles (11* with parity). Each back-to-back frame adds the one-cycle CleanUp gap.
- TxStart while TxBusy=1: ignored, no queuing, no error flag.
- TxDataIn changes after acceptance: no effect on the frame in flight.
- TxDone is never asserted outside CleanUp; it is never high for two consecutive cycles.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a ParityBit state is inserted between DataBits and StopBit.
  - TxSerial = XOR of the captured byte, XOR ParityOdd, held for ClocksPerBit cycles.
  - Frame = 11 bits.
- Undefined: ParityBit state and parity logic are absent; frame = 10 bits (8N1). ParityOdd is unused.

Decomposition:
- Package uart_pkg:
  - state encoding constants (3-bit) shared with the receiver;
  - ClocksPerBit presets for 9600 and 115200 at 100 MHz;
  - DataBitsPerFrame=8;
  - IdleLevel=1'b1.
- One natural sub-module, uart_bit_timer:
  - inputs: Clk, Rst_n, clear;
  - output: a BitEnd pulse when the count reaches ClocksPerBit-1;
  - reusable by the receiver later.

Test Plan:
- Reset mid-frame: ClocksPerBit=16, send 0xA5, pull Rst_n low during bit 3 -> TxSerial=1, TxBusy=0 within the same cycle; no TxDone; the next request sends a clean frame.
- Single byte: ClocksPerBit=16, TxStart with 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; TxDone pulses once, 160 cycles after the start-bit fall.
- Busy ignore: ClocksPerBit=16, TxStart with 0x3C at cycle 40 of a 0x55 frame -> the 0x55 frame is unchanged; no second frame follows.
- Back-to-back: ClocksPerBit=16, assert TxStart with 0x00 in the CleanUp cycle of an 0xFF frame -> the next start bit begins one cycle after TxDone; the 0x00 frame is correct.
- Loopback: ClocksPerBit=868, drive TxSerial into the receiver, send 0x00, 0xFF, 0x5A, 0x81 -> receiver RxDataOut matches each byte in order.
- Parity (UART_TX_PARITY_EN, ParityOdd=0): ClocksPerBit=16, send 0x07 -> parity bit=1, frame 176 cycles; with ParityOdd=1 -> parity bit=0.
